gprs_writeback_queue: RTL and testbench

//  Write-back stage directly upstream of the general-purpose register file (GPRs).

---
 rtl/gprs_pkg.sv | 22 ++
 rtl/gprs_wbq_match.sv | 43 ++++
 rtl/gprs_writeback_queue.sv | 127 ++++++++++++
 tb/tb_gprs_writeback_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/gprs_pkg.sv
// Shared definitions for the GPR write-back path: default register file
// geometry, index-width helper and the default queue entry layout.
package gprs_pkg;

  localparam int GPRS_WIDTH = 32;
  localparam int GPRS_UNITS = 32;

  // Index width for a register file of 'units' entries (at least one bit).
  function automatic int gprs_iw(input int units);
    return (units > 1) ? $clog2(units) : 1;
  endfunction

  localparam int GPRS_IW = gprs_iw(GPRS_UNITS);

  // Queue entry for the default geometry; parameterised instances build
  // an identically shaped local type.
  typedef struct packed {
    logic [GPRS_IW-1:0]    dst;
    logic [GPRS_WIDTH-1:0] data;
  } gprs_entry_t;

endpackage

// File: rtl/gprs_wbq_match.sv
// Youngest-first match of one read select against the live queue entries.
// Walks from head (oldest) toward tail so the last hit seen is the youngest.
// Only instantiated when GPRS_WBQ_FWD_EN is defined.
module gprs_wbq_match
  import gprs_pkg::*;
#(
  parameter int ZERO  = 0,
  parameter int WIDTH = GPRS_WIDTH,
  parameter int IW    = GPRS_IW,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic [AW-1:0]                head_i,
  input  logic [CW-1:0]                cnt_i,
  input  logic [DEPTH-1:0][IW-1:0]     dst_i,
  input  logic [DEPTH-1:0][WIDTH-1:0]  data_i,
  input  logic [IW-1:0]                sel_i,
  output logic                         hit_o,
  output logic [WIDTH-1:0]             data_o
);

  // Scan oldest to youngest; later hits overwrite earlier ones.
  always_comb begin
    logic [AW-1:0] idx;
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + AW'(k);
      if ((CW'(k) < cnt_i) && (dst_i[idx] == sel_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
    // A hard-wired zero register never has a pending value.
    if ((ZERO != 0) && (sel_i == '0)) begin
      hit_o  = 1'b0;
      data_o = '0;
    end
  end

endmodule

// File: rtl/gprs_writeback_queue.sv
// In-order write-back queue in front of the GPR file. Merges ALU (A) and
// load (B) results, A ahead of B on a shared edge, and drains one entry
// per cycle into the single GPR write port.
// Optional read-stage forwarding of queued results: define GPRS_WBQ_FWD_EN.
module gprs_writeback_queue
  import gprs_pkg::*;
#(
  parameter int ZERO  = 0,
  parameter int WIDTH = GPRS_WIDTH,
  parameter int UNITS = GPRS_UNITS,
  parameter int DEPTH = 4,
  localparam int IW   = gprs_iw(UNITS),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             AV,
  output logic             AR,
  input  logic [IW-1:0]    As,
  input  logic [WIDTH-1:0] Ad,
  input  logic             BV,
  output logic             BR,
  input  logic [IW-1:0]    Bs,
  input  logic [WIDTH-1:0] Bd,
  input  logic             HOLD,
  output logic             WEN,
  output logic [IW-1:0]    DSTs,
  output logic [WIDTH-1:0] DSTi,
  output logic [CW-1:0]    CNT,
  input  logic [IW-1:0]    RS1s,
  input  logic [IW-1:0]    RS2s,
  output logic             RS1h,
  output logic             RS2h,
  output logic [WIDTH-1:0] RS1f,
  output logic [WIDTH-1:0] RS2f
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M2 = CW'(DEPTH - 2);

  typedef struct packed {
    logic [IW-1:0]    dst;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [CW-1:0] wp_q, wp_d;
  logic [CW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt;
  logic          push_a, push_b, pop;
  logic [AW-1:0] wa_idx, wb_idx, rd_idx;

  // Pointers carry one extra wrap bit, so their difference is the occupancy.
  assign cnt = wp_q - rp_q;
  assign CNT = cnt;

  // Credit comes only from registered occupancy; a same-cycle pop frees nothing.
  assign AR = !RST && (cnt < DEPTH_C);
  assign BR = !RST && (AV ? (cnt <= DEPTH_M2) : (cnt < DEPTH_C));

  // Writes to a hard-wired zero register are acknowledged but take no slot.
  assign push_a = AV && AR && !((ZERO != 0) && (As == '0));
  assign push_b = BV && BR && !((ZERO != 0) && (Bs == '0));

  assign pop    = (cnt != '0) && !HOLD && !RST;
  assign WEN    = pop;
  assign rd_idx = rp_q[AW-1:0];
  assign DSTs   = mem_q[rd_idx].dst;
  assign DSTi   = mem_q[rd_idx].data;

  // B lands one slot past A when both push on the same edge.
  assign wa_idx = wp_q[AW-1:0];
  assign wb_idx = wp_q[AW-1:0] + AW'(push_a);
  assign wp_d   = wp_q + CW'(push_a) + CW'(push_b);
  assign rp_d   = rp_q + CW'(pop);

  // Pointer state; reset empties the queue and discards all pending writes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Entry storage; contents are meaningless outside the live window.
  always_ff @(posedge CLK) begin
    if (push_a) mem_q[wa_idx] <= '{dst: As, data: Ad};
    if (push_b) mem_q[wb_idx] <= '{dst: Bs, data: Bd};
  end

`ifdef GPRS_WBQ_FWD_EN
  logic [DEPTH-1:0][IW-1:0]    q_dst;
  logic [DEPTH-1:0][WIDTH-1:0] q_dat;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign q_dst[g] = mem_q[g].dst;
    assign q_dat[g] = mem_q[g].data;
  end

  gprs_wbq_match #(
    .ZERO(ZERO), .WIDTH(WIDTH), .IW(IW), .DEPTH(DEPTH)
  ) u_match_rs1 (
    .head_i(rd_idx), .cnt_i(cnt), .dst_i(q_dst), .data_i(q_dat),
    .sel_i(RS1s), .hit_o(RS1h), .data_o(RS1f)
  );

  gprs_wbq_match #(
    .ZERO(ZERO), .WIDTH(WIDTH), .IW(IW), .DEPTH(DEPTH)
  ) u_match_rs2 (
    .head_i(rd_idx), .cnt_i(cnt), .dst_i(q_dst), .data_i(q_dat),
    .sel_i(RS2s), .hit_o(RS2h), .data_o(RS2f)
  );
`else
  // No forwarding: read selects are ignored and outputs are tied off.
  logic unused_rs;
  assign unused_rs = ^{RS1s, RS2s};
  assign RS1h = 1'b0;
  assign RS2h = 1'b0;
  assign RS1f = '0;
  assign RS2f = '0;
`endif

endmodule

// File: tb/tb_gprs_writeback_queue.sv
// Directed bench for gprs_writeback_queue (ZERO=1, DEPTH=4, 32x32 GPRs).
module tb_gprs_writeback_queue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        AV, BV, HOLD;
  logic        AR, BR, WEN;
  logic [4:0]  As, Bs, DSTs, RS1s, RS2s;
  logic [31:0] Ad, Bd, DSTi, RS1f, RS2f;
  logic [2:0]  CNT;
  logic        RS1h, RS2h;

  int checks = 0;
  int errors = 0;
  logic [31:0] gpr [32];

  always #5 CLK = ~CLK;

  gprs_writeback_queue #(.ZERO(1), .WIDTH(32), .UNITS(32), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .AV(AV), .AR(AR), .As(As), .Ad(Ad),
    .BV(BV), .BR(BR), .Bs(Bs), .Bd(Bd),
    .HOLD(HOLD), .WEN(WEN), .DSTs(DSTs), .DSTi(DSTi), .CNT(CNT),
    .RS1s(RS1s), .RS2s(RS2s), .RS1h(RS1h), .RS2h(RS2h), .RS1f(RS1f), .RS2f(RS2f)
  );

  // GPR file model: captures whatever the queue writes.
  always @(posedge CLK) if (WEN) gpr[DSTs] <= DSTi;

  // Occupancy must never exceed DEPTH.
  always @(negedge CLK) if (CNT > 3'd4) begin
    errors++;
    $display("FAIL cnt_bound CNT=%0d max=4", CNT);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1; AV = 1; BV = 1; As = 5'd1; Bs = 5'd2; Ad = 32'h1; Bd = 32'h2;
    HOLD = 0; RS1s = 0; RS2s = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (AR !== 1'b0) begin errors++; $display("FAIL rst_ar got=%b exp=0", AR); end
      checks++; if (BR !== 1'b0) begin errors++; $display("FAIL rst_br got=%b exp=0", BR); end
      checks++; if (WEN !== 1'b0) begin errors++; $display("FAIL rst_wen got=%b exp=0", WEN); end
      checks++; if (CNT !== 3'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", CNT); end
    end
    AV = 0; BV = 0; RST = 0;
    #1;
    checks++; if (AR !== 1'b1) begin errors++; $display("FAIL post_rst_ar got=%b exp=1", AR); end
    step();
    checks++; if (CNT !== 3'd0) begin errors++; $display("FAIL post_rst_cnt got=%0d exp=0", CNT); end
  endtask

  task automatic test_single_a();
    AV = 1; As = 5'd5; Ad = 32'hDEADBEEF;
    #1;
    checks++; if (AR !== 1'b1) begin errors++; $display("FAIL single_ar got=%b exp=1", AR); end
    step();
    AV = 0;
    checks++; if (WEN !== 1'b1) begin errors++; $display("FAIL single_wen got=%b exp=1", WEN); end
    checks++; if (DSTs !== 5'd5) begin errors++; $display("FAIL single_dsts got=%0d exp=5", DSTs); end
    checks++; if (DSTi !== 32'hDEADBEEF) begin errors++; $display("FAIL single_dsti got=%h exp=deadbeef", DSTi); end
    checks++; if (CNT !== 3'd1) begin errors++; $display("FAIL single_cnt1 got=%0d exp=1", CNT); end
    step();
    checks++; if (WEN !== 1'b0) begin errors++; $display("FAIL single_wen_off got=%b exp=0", WEN); end
    checks++; if (CNT !== 3'd0) begin errors++; $display("FAIL single_cnt0 got=%0d exp=0", CNT); end
    checks++; if (gpr[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_gpr5 got=%h exp=deadbeef", gpr[5]); end
  endtask

  task automatic test_dual_push();
    AV = 1; As = 5'd3; Ad = 32'h11;
    BV = 1; Bs = 5'd3; Bd = 32'h22;
    #1;
    checks++; if (BR !== 1'b1) begin errors++; $display("FAIL dual_br got=%b exp=1", BR); end
    step();
    AV = 0; BV = 0;
    checks++; if (CNT !== 3'd2) begin errors++; $display("FAIL dual_cnt2 got=%0d exp=2", CNT); end
    checks++; if (WEN !== 1'b1 || DSTi !== 32'h11) begin errors++; $display("FAIL dual_first got=%b/%h exp=1/11", WEN, DSTi); end
    step();
    checks++; if (WEN !== 1'b1 || DSTi !== 32'h22) begin errors++; $display("FAIL dual_second got=%b/%h exp=1/22", WEN, DSTi); end
    checks++; if (gpr[3] !== 32'h11) begin errors++; $display("FAIL dual_gpr3_mid got=%h exp=11", gpr[3]); end
    step();
    checks++; if (WEN !== 1'b0 || CNT !== 3'd0) begin errors++; $display("FAIL dual_end got=%b/%0d exp=0/0", WEN, CNT); end
    checks++; if (gpr[3] !== 32'h22) begin errors++; $display("FAIL dual_gpr3 got=%h exp=22", gpr[3]); end
  endtask

  task automatic test_full_hold();
    HOLD = 1;
    for (int i = 0; i < 4; i++) begin
      AV = 1; As = 5'(10 + i); Ad = 32'(100 + i);
      #1;
      if (i == 3) begin
        checks++; if (AR !== 1'b1) begin errors++; $display("FAIL full_ar_cnt3 got=%b exp=1", AR); end
        checks++; if (BR !== 1'b0) begin errors++; $display("FAIL full_br_av got=%b exp=0", BR); end
      end
      step();
    end
    AV = 0;
    #1;
    checks++; if (CNT !== 3'd4) begin errors++; $display("FAIL full_cnt got=%0d exp=4", CNT); end
    checks++; if (AR !== 1'b0) begin errors++; $display("FAIL full_ar got=%b exp=0", AR); end
    checks++; if (BR !== 1'b0) begin errors++; $display("FAIL full_br got=%b exp=0", BR); end
    checks++; if (WEN !== 1'b0) begin errors++; $display("FAIL full_hold_wen got=%b exp=0", WEN); end
    HOLD = 0;
    #1;
    checks++; if (AR !== 1'b0) begin errors++; $display("FAIL full_nocredit got=%b exp=0", AR); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (WEN !== 1'b1 || DSTs !== 5'(10 + i) || DSTi !== 32'(100 + i)) begin
        errors++; $display("FAIL full_drain%0d got=%b/%0d/%0d exp=1/%0d/%0d", i, WEN, DSTs, DSTi, 10 + i, 100 + i);
      end
      step();
      if (i == 0) begin
        checks++; if (AR !== 1'b1) begin errors++; $display("FAIL full_ar_after_pop got=%b exp=1", AR); end
      end
    end
    checks++; if (WEN !== 1'b0 || CNT !== 3'd0) begin errors++; $display("FAIL full_end got=%b/%0d exp=0/0", WEN, CNT); end
    checks++; if (gpr[13] !== 32'd103) begin errors++; $display("FAIL full_gpr13 got=%0d exp=103", gpr[13]); end
  endtask

  task automatic test_zero();
    AV = 1; As = 5'd0; Ad = 32'hFFFF;
    #1;
    checks++; if (AR !== 1'b1) begin errors++; $display("FAIL zero_ar got=%b exp=1", AR); end
    step();
    AV = 0;
    checks++; if (CNT !== 3'd0) begin errors++; $display("FAIL zero_cnt got=%0d exp=0", CNT); end
    checks++; if (WEN !== 1'b0) begin errors++; $display("FAIL zero_wen got=%b exp=0", WEN); end
    step();
    checks++; if (WEN !== 1'b0) begin errors++; $display("FAIL zero_wen2 got=%b exp=0", WEN); end
  endtask

  task automatic test_fwd();
    logic        exp_h;
    logic [31:0] exp_f;
`ifdef GPRS_WBQ_FWD_EN
    exp_h = 1'b1; exp_f = 32'hB;
`else
    exp_h = 1'b0; exp_f = 32'h0;
`endif
    HOLD = 1;
    AV = 1; As = 5'd7; Ad = 32'hA;
    BV = 1; Bs = 5'd7; Bd = 32'hB;
    step();
    AV = 0; BV = 0;
    RS1s = 5'd7; RS2s = 5'd8;
    #1;
    checks++; if (RS1h !== exp_h) begin errors++; $display("FAIL fwd_rs1h got=%b exp=%b", RS1h, exp_h); end
    checks++; if (RS1f !== exp_f) begin errors++; $display("FAIL fwd_rs1f got=%h exp=%h", RS1f, exp_f); end
    checks++; if (RS2h !== 1'b0) begin errors++; $display("FAIL fwd_rs2h got=%b exp=0", RS2h); end
    RS2s = 5'd0;
    #1;
    checks++; if (RS2h !== 1'b0) begin errors++; $display("FAIL fwd_zero_h got=%b exp=0", RS2h); end
    HOLD = 0;
    step();
    checks++; if (RS1h !== exp_h || RS1f !== exp_f) begin errors++; $display("FAIL fwd_head got=%b/%h exp=%b/%h", RS1h, RS1f, exp_h, exp_f); end
    step();
    checks++; if (RS1h !== 1'b0 || CNT !== 3'd0) begin errors++; $display("FAIL fwd_empty got=%b/%0d exp=0/0", RS1h, CNT); end
    RS1s = 0;
  endtask

  task automatic test_mid_reset();
    HOLD = 1;
    for (int i = 0; i < 3; i++) begin
      AV = 1; As = 5'(20 + i); Ad = 32'(200 + i);
      step();
    end
    AV = 0;
    checks++; if (CNT !== 3'd3) begin errors++; $display("FAIL midrst_cnt3 got=%0d exp=3", CNT); end
    RST = 1;
    #1;
    checks++; if (AR !== 1'b0 || WEN !== 1'b0) begin errors++; $display("FAIL midrst_during got=%b/%b exp=0/0", AR, WEN); end
    step();
    RST = 0; HOLD = 0;
    checks++; if (CNT !== 3'd0) begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", CNT); end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (WEN !== 1'b0) begin errors++; $display("FAIL midrst_wen%0d got=%b exp=0", i, WEN); end
      step();
    end
    checks++; if (gpr[20] === 32'd200) begin errors++; $display("FAIL midrst_gpr20 got=%0d exp=not 200", gpr[20]); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gpr[i] = 32'h0;
    test_reset();
    test_single_a();
    test_dual_push();
    test_full_hold();
    test_zero();
    test_fwd();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
